mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter_pkg.sv | 32 +++
 rtl/mem_arbiter_if.sv | 45 ++++
 rtl/arb_timer.sv | 35 +++
 rtl/mem_arbiter.sv | 130 +++++++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types for the memory arbiter.
//   arb_state_t : arbiter FSM state (IDLE, I_BUSY, D_BUSY)
//   mem_cmd_t   : one registered memory request (we/addr/wdata/be)
//   fetch_cmd() : builds the read-only, full-word request used for fetches
package mem_arbiter_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned BE_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

  typedef struct packed {
    logic            we;
    logic [XLEN-1:0] addr;
    logic [XLEN-1:0] wdata;
    logic [BE_W-1:0] be;
  } mem_cmd_t;

  function automatic mem_cmd_t fetch_cmd(input logic [XLEN-1:0] addr);
    mem_cmd_t cmd;
    cmd.we    = 1'b0;
    cmd.addr  = addr;
    cmd.wdata = '0;
    cmd.be    = '1;
    return cmd;
  endfunction

endpackage

// File: rtl/mem_arbiter_if.sv
// Bundle of the fetch port, data port, memory port and hazard-unit stalls around the arbiter.
//   slave  : arbiter view (requests and mem_ack/mem_rdata in; grants, data, stalls out)
//   master : environment view (requesters, memory and hazard unit)
interface mem_arbiter_if;
  import mem_arbiter_pkg::*;

  // Fetch port
  logic            if_req;
  logic [XLEN-1:0] if_addr;
  logic [XLEN-1:0] if_rdata;
  logic            if_done;
  // Data port
  logic            d_req;
  logic            d_we;
  logic [XLEN-1:0] d_addr;
  logic [XLEN-1:0] d_wdata;
  logic [BE_W-1:0] d_be;
  logic [XLEN-1:0] d_rdata;
  logic            d_done;
  // Single-port memory
  logic            mem_req;
  logic            mem_we;
  logic [XLEN-1:0] mem_addr;
  logic [XLEN-1:0] mem_wdata;
  logic [BE_W-1:0] mem_be;
  logic            mem_ack;
  logic [XLEN-1:0] mem_rdata;
  // Status
  logic            bus_err;
  logic            stall_if;
  logic            stall_mem;

  modport slave (
    input  if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    output if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           bus_err, stall_if, stall_mem
  );

  modport master (
    output if_req, if_addr, d_req, d_we, d_addr, d_wdata, d_be, mem_ack, mem_rdata,
    input  if_rdata, if_done, d_rdata, d_done, mem_req, mem_we, mem_addr, mem_wdata, mem_be,
           bus_err, stall_if, stall_mem
  );

endinterface

// File: rtl/arb_timer.sv
// Clearable saturating up-counter with a terminal flag.
//   clk, reset : clock, asynchronous active-high reset
//   clr        : synchronous clear (wins over inc)
//   inc        : count this cycle; the count saturates at Limit
//   term       : high when this increment brings the count to Limit
module arb_timer #(
  parameter int unsigned Limit = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic inc,
  output logic term
);

  localparam int unsigned CntW = $clog2(Limit + 1);
  localparam logic [CntW-1:0] CntMax  = CntW'(Limit);
  localparam logic [CntW-1:0] CntLast = CntW'(Limit - 1);

  logic [CntW-1:0] count_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count_q <= '0;
    end else if (clr) begin
      count_q <= '0;
    end else if (inc && (count_q != CntMax)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Flagging on the final increment makes the Limit-th idle busy cycle the last one.
  assign term = inc & (count_q == CntLast);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates a fetch port and a data port onto one single-port memory, one transaction at a time.
//   clk, reset : clock, asynchronous active-high reset
//   bus        : mem_arbiter_if.slave -- fetch/data ports, memory port, bus_err and stalls
// Data wins in IDLE unless the fetch side has been passed over STARVE_LIMIT times in a row.
// A transaction with no mem_ack for MAX_WAIT busy cycles completes with bus_err and rdata 0.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned MAX_WAIT     = 255
) (
  input logic          clk,
  input logic          reset,
  mem_arbiter_if.slave bus
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  arb_state_t       state_q, state_d;
  logic             grant_i, grant_d;
  logic             busy, timeout, finish;
  mem_cmd_t         cmd_q;
  logic [StarveW-1:0] starve_q;
  logic [XLEN-1:0]  if_rdata_q, d_rdata_q;
  logic             if_done_q, d_done_q, bus_err_q;

  assign busy   = (state_q != IDLE);
  assign finish = busy & (bus.mem_ack | timeout);

  arb_timer #(
    .Limit(MAX_WAIT)
  ) u_wait_timer (
    .clk  (clk),
    .reset(reset),
    .clr  (grant_i | grant_d),
    .inc  (busy & ~bus.mem_ack),
    .term (timeout)
  );

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and grant decision
  always_comb begin
    state_d = state_q;
    grant_i = 1'b0;
    grant_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (bus.d_req && !(bus.if_req && (starve_q == StarveMax))) begin
          grant_d = 1'b1;
          state_d = D_BUSY;
        end else if (bus.if_req) begin
          grant_i = 1'b1;
          state_d = I_BUSY;
        end
      end
      I_BUSY, D_BUSY: begin
        if (bus.mem_ack || timeout) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Outputs
  always_comb begin
    bus.mem_req   = busy;
    bus.mem_we    = cmd_q.we;
    bus.mem_addr  = cmd_q.addr;
    bus.mem_wdata = cmd_q.wdata;
    bus.mem_be    = cmd_q.be;
    bus.if_rdata  = if_rdata_q;
    bus.if_done   = if_done_q;
    bus.d_rdata   = d_rdata_q;
    bus.d_done    = d_done_q;
    bus.bus_err   = bus_err_q;
    bus.stall_if  = bus.if_req & ~if_done_q;
    bus.stall_mem = bus.d_req & ~d_done_q;
  end

  // Request capture, starve count and completion datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cmd_q      <= '0;
      starve_q   <= '0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
      if_done_q  <= 1'b0;
      d_done_q   <= 1'b0;
      bus_err_q  <= 1'b0;
    end else begin
      if_done_q <= 1'b0;
      d_done_q  <= 1'b0;
      bus_err_q <= 1'b0;
      if (grant_i) begin
        cmd_q    <= fetch_cmd(bus.if_addr);
        starve_q <= '0;
      end
      if (grant_d) begin
        cmd_q <= '{we: bus.d_we, addr: bus.d_addr, wdata: bus.d_wdata, be: bus.d_be};
        if (bus.if_req && (starve_q != StarveMax)) begin
          starve_q <= starve_q + 1'b1;
        end
      end
      // timeout only fires on cycles without mem_ack, so the two never coincide
      if (finish) begin
        bus_err_q <= ~bus.mem_ack;
        if (state_q == I_BUSY) begin
          if_done_q  <= 1'b1;
          if_rdata_q <= bus.mem_ack ? bus.mem_rdata : '0;
        end else begin
          d_done_q <= 1'b1;
          if (!cmd_q.we) begin
            d_rdata_q <= bus.mem_ack ? bus.mem_rdata : '0;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: store, data/fetch collision, starvation order, timeout,
// reset mid-transaction and a stray mem_ack in IDLE.
module tb_mem_arbiter;

  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  mem_arbiter_if bus ();

  mem_arbiter #(
    .STARVE_LIMIT(4),
    .MAX_WAIT    (255)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic all_busy;
    logic is_fetch;

    reset         = 1'b1;
    bus.if_req    = 1'b0;
    bus.if_addr   = '0;
    bus.d_req     = 1'b0;
    bus.d_we      = 1'b0;
    bus.d_addr    = '0;
    bus.d_wdata   = '0;
    bus.d_be      = '0;
    bus.mem_ack   = 1'b0;
    bus.mem_rdata = '0;
    step();
    step();

    // Reset state
    check("rst_mem_req", 32'(bus.mem_req), 32'd0);
    check("rst_if_done", 32'(bus.if_done), 32'd0);
    check("rst_d_done", 32'(bus.d_done), 32'd0);
    check("rst_bus_err", 32'(bus.bus_err), 32'd0);
    check("rst_d_rdata", bus.d_rdata, 32'h0);
    check("rst_if_rdata", bus.if_rdata, 32'h0);
    reset = 1'b0;
    step();

    // Store to 0x100, mem_ack three cycles after mem_req rises
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b1;
    bus.d_addr  = 32'h100;
    bus.d_wdata = 32'hDEADBEEF;
    bus.d_be    = 4'hF;
    #1;
    check("st_stall_mem", 32'(bus.stall_mem), 32'd1);
    check("st_req_idle", 32'(bus.mem_req), 32'd0);
    step();
    check("st_mem_req", 32'(bus.mem_req), 32'd1);
    check("st_mem_we", 32'(bus.mem_we), 32'd1);
    check("st_mem_addr", bus.mem_addr, 32'h100);
    check("st_mem_wdata", bus.mem_wdata, 32'hDEADBEEF);
    check("st_mem_be", 32'(bus.mem_be), 32'hF);
    step();
    step();
    check("st_wait_req", 32'(bus.mem_req), 32'd1);
    check("st_wait_done", 32'(bus.d_done), 32'd0);
    step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h77777777;
    step();
    check("st_d_done", 32'(bus.d_done), 32'd1);
    check("st_bus_err", 32'(bus.bus_err), 32'd0);
    check("st_rdata_hold", bus.d_rdata, 32'h0);
    check("st_stall_clr", 32'(bus.stall_mem), 32'd0);
    check("st_req_low", 32'(bus.mem_req), 32'd0);
    bus.d_req   = 1'b0;
    bus.mem_ack = 1'b0;
    step();
    check("st_done_pulse", 32'(bus.d_done), 32'd0);

    // Fetch 0x0 and load 0x200 together, ack latency 1: data first, then fetch
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h0;
    bus.d_req   = 1'b1;
    bus.d_we    = 1'b0;
    bus.d_addr  = 32'h200;
    step();
    check("co_d_addr", bus.mem_addr, 32'h200);
    check("co_d_we", 32'(bus.mem_we), 32'd0);
    check("co_stall_if1", 32'(bus.stall_if), 32'd1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h11112222;
    step();
    check("co_d_done", 32'(bus.d_done), 32'd1);
    check("co_d_rdata", bus.d_rdata, 32'h11112222);
    check("co_stall_if2", 32'(bus.stall_if), 32'd1);
    bus.d_req   = 1'b0;
    bus.mem_ack = 1'b0;
    step();
    check("co_i_addr", bus.mem_addr, 32'h0);
    check("co_i_be", 32'(bus.mem_be), 32'hF);
    check("co_i_we", 32'(bus.mem_we), 32'd0);
    check("co_stall_if3", 32'(bus.stall_if), 32'd1);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hCAFEF00D;
    step();
    check("co_if_done", 32'(bus.if_done), 32'd1);
    check("co_if_rdata", bus.if_rdata, 32'hCAFEF00D);
    check("co_stall_if4", 32'(bus.stall_if), 32'd0);
    check("co_d_rdata_hold", bus.d_rdata, 32'h11112222);
    bus.if_req  = 1'b0;
    bus.mem_ack = 1'b0;
    step();

    // Continuous requests from both ports: grant order D,D,D,D,I repeating
    bus.if_req    = 1'b1;
    bus.if_addr   = 32'h40;
    bus.d_req     = 1'b1;
    bus.d_we      = 1'b0;
    bus.d_addr    = 32'h300;
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h5A5A5A5A;
    for (int i = 0; i < 10; i++) begin
      is_fetch = ((i % 5) == 4);
      step();
      check($sformatf("sv_req_%0d", i), 32'(bus.mem_req), 32'd1);
      check($sformatf("sv_addr_%0d", i), bus.mem_addr, is_fetch ? 32'h40 : 32'h300);
      step();
      check($sformatf("sv_ifdone_%0d", i), 32'(bus.if_done), 32'(is_fetch));
      check($sformatf("sv_ddone_%0d", i), 32'(bus.d_done), 32'(!is_fetch));
    end
    bus.if_req  = 1'b0;
    bus.d_req   = 1'b0;
    bus.mem_ack = 1'b0;
    step();
    check("sv_quiet", 32'(bus.mem_req), 32'd0);

    // No mem_ack: timeout after 255 busy cycles with bus_err and rdata 0
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h400;
    all_busy   = 1'b1;
    for (int i = 0; i < 254; i++) begin
      step();
      if (!(bus.mem_req === 1'b1 && bus.d_done === 1'b0 && bus.bus_err === 1'b0)) begin
        all_busy = 1'b0;
      end
    end
    check("to_busy_run", 32'(all_busy), 32'd1);
    step();
    check("to_last_busy", 32'(bus.mem_req), 32'd1);
    check("to_last_nodone", 32'(bus.d_done), 32'd0);
    step();
    check("to_d_done", 32'(bus.d_done), 32'd1);
    check("to_bus_err", 32'(bus.bus_err), 32'd1);
    check("to_rdata_zero", bus.d_rdata, 32'h0);
    check("to_idle", 32'(bus.mem_req), 32'd0);
    bus.d_req   = 1'b0;
    bus.if_req  = 1'b1;
    bus.if_addr = 32'h80;
    step();
    check("to_next_req", 32'(bus.mem_req), 32'd1);
    check("to_next_addr", bus.mem_addr, 32'h80);
    check("to_err_clear", 32'(bus.bus_err), 32'd0);
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h12345678;
    step();
    check("to_next_done", 32'(bus.if_done), 32'd1);
    check("to_next_err", 32'(bus.bus_err), 32'd0);
    check("to_next_rdata", bus.if_rdata, 32'h12345678);
    bus.if_req  = 1'b0;
    bus.mem_ack = 1'b0;
    step();

    // Reset two cycles into D_BUSY
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h500;
    step();
    check("rs_busy", 32'(bus.mem_req), 32'd1);
    step();
    reset     = 1'b1;
    bus.d_req = 1'b0;
    #1;
    check("rs_req_drop", 32'(bus.mem_req), 32'd0);
    check("rs_if_rdata", bus.if_rdata, 32'h0);
    step();
    check("rs_no_done_a", 32'(bus.d_done), 32'd0);
    reset = 1'b0;
    step();
    check("rs_idle", 32'(bus.mem_req), 32'd0);
    check("rs_no_done_b", 32'(bus.d_done), 32'd0);
    step();
    check("rs_no_done_c", 32'(bus.d_done), 32'd0);

    // mem_ack while IDLE is ignored
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'hBAD0BAD0;
    step();
    check("ia_if_done", 32'(bus.if_done), 32'd0);
    check("ia_d_done", 32'(bus.d_done), 32'd0);
    check("ia_idle", 32'(bus.mem_req), 32'd0);
    check("ia_rdata", bus.d_rdata, 32'h0);
    bus.mem_ack = 1'b0;
    step();
    check("ia_idle2", 32'(bus.mem_req), 32'd0);

    // Normal load afterwards, ack latency 2
    bus.d_req  = 1'b1;
    bus.d_we   = 1'b0;
    bus.d_addr = 32'h600;
    step();
    check("ld_req", 32'(bus.mem_req), 32'd1);
    check("ld_addr", bus.mem_addr, 32'h600);
    step();
    bus.mem_ack   = 1'b1;
    bus.mem_rdata = 32'h0600F00D;
    step();
    check("ld_done", 32'(bus.d_done), 32'd1);
    check("ld_rdata", bus.d_rdata, 32'h0600F00D);
    check("ld_err", 32'(bus.bus_err), 32'd0);
    bus.d_req   = 1'b0;
    bus.mem_ack = 1'b0;
    step();
    check("ld_pulse", 32'(bus.d_done), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
